// File: rtl/fpnew_divsqrt_arbiter.sv
// Round-robin arbiter sharing one multi-cycle div/sqrt unit among NumReq requesters.
// One operation in flight; the result is registered and returned to the requester that issued it.
module fpnew_divsqrt_arbiter #(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned DataWidth = 140,
   parameter int unsigned ResWidth  = 69
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic [NumReq-1:0]           req_valid_i,
   output logic [NumReq-1:0]           req_ready_o,
   input  logic [NumReq*DataWidth-1:0] req_data_i,
   output logic                        unit_valid_o,
   input  logic                        unit_ready_i,
   output logic [DataWidth-1:0]        unit_data_o,
   input  logic                        unit_out_valid_i,
   output logic                        unit_out_ready_o,
   input  logic [ResWidth-1:0]         unit_result_i,
   output logic                        unit_flush_o,
   output logic [NumReq-1:0]           resp_valid_o,
   input  logic [NumReq-1:0]           resp_ready_i,
   output logic [ResWidth-1:0]         resp_result_o,
   output logic                        busy_o
);

   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]          state, state_next;
   logic [IdxW-1:0]     rr_ptr, owner_q, locked_q;
   logic [IdxW-1:0]     search_idx, winner, winner_inc;
   logic                lock_q, any_valid, kill, unit_valid, issue;
   logic [ResWidth-1:0] result_q;

   // Descending scan so the lowest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      search_idx = rr_ptr;
      any_valid  = 1'b0;
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
         int              k;
         logic [IdxW-1:0] cand;
         k = int'(rr_ptr) + i;
         if (k >= int'(NumReq)) k = k - int'(NumReq);
         cand = IdxW'(k);
         if (req_valid_i[cand]) begin
            search_idx = cand;
            any_valid  = 1'b1;
         end
      end
   end

   // An offer that stalled on unit_ready_i keeps its winner until accepted.
   assign winner     = lock_q ? locked_q : search_idx;
   assign winner_inc = (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;

   // Reset and flush both blank every handshake output in the same cycle.
   assign kill       = flush_i | ~rst_ni;
   assign unit_valid = (state == IDLE) & (any_valid | lock_q) & ~kill;
   assign issue      = unit_valid & unit_ready_i;

   assign unit_valid_o     = unit_valid;
   assign unit_data_o      = kill ? '0 : req_data_i[int'(winner)*DataWidth +: DataWidth];
   assign unit_out_ready_o = (state == BUSY) & ~kill;
   assign unit_flush_o     = flush_i;
   assign resp_result_o    = kill ? '0 : result_q;
   assign busy_o           = (state != IDLE) & ~kill;

   always_comb begin
      req_ready_o  = '0;
      resp_valid_o = '0;
      if (unit_valid) req_ready_o[winner] = unit_ready_i;
      if ((state == RESP) && !kill) resp_valid_o[owner_q] = 1'b1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (issue) state_next = BUSY;
         BUSY:    if (unit_out_valid_i) state_next = RESP;
         RESP:    if (resp_ready_i[owner_q]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner_q  <= '0;
         locked_q <= '0;
         lock_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state <= state_next;
         if (flush_i) begin
            lock_q <= 1'b0;
         end else if (issue) begin
            owner_q <= winner;
            rr_ptr  <= winner_inc;
            lock_q  <= 1'b0;
         end else if (unit_valid) begin
            lock_q   <= 1'b1;
            locked_q <= winner;
         end
         if ((state == BUSY) && unit_out_valid_i && !flush_i) result_q <= unit_result_i;
      end
   end

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Directed bench for fpnew_divsqrt_arbiter: stimulus pushes expected issues/responses,
// a negedge monitor pops them whenever the DUT completes a handshake.
module tb_fpnew_divsqrt_arbiter;
   localparam int NR = 4;
   localparam int DW = 140;
   localparam int RW = 69;

   typedef struct packed {
      logic [NR-1:0] oh;
      logic [RW-1:0] res;
   } resp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready_o;
   logic [NR*DW-1:0] req_data;
   logic             unit_valid_o;
   logic             unit_ready;
   logic [DW-1:0]    unit_data_o;
   logic             unit_out_valid;
   logic             unit_out_ready_o;
   logic [RW-1:0]    unit_result;
   logic             unit_flush_o;
   logic [NR-1:0]    resp_valid_o;
   logic [NR-1:0]    resp_ready;
   logic [RW-1:0]    resp_result_o;
   logic             busy_o;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] exp_issue[$];
   resp_t         exp_resp[$];
   logic [DW-1:0] mon_e;
   resp_t         mon_r;

   always #5 clk = ~clk;

   fpnew_divsqrt_arbiter #(.NumReq(NR), .DataWidth(DW), .ResWidth(RW)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .flush_i          (flush),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready_o),
      .req_data_i       (req_data),
      .unit_valid_o     (unit_valid_o),
      .unit_ready_i     (unit_ready),
      .unit_data_o      (unit_data_o),
      .unit_out_valid_i (unit_out_valid),
      .unit_out_ready_o (unit_out_ready_o),
      .unit_result_i    (unit_result),
      .unit_flush_o     (unit_flush_o),
      .resp_valid_o     (resp_valid_o),
      .resp_ready_i     (resp_ready),
      .resp_result_o    (resp_result_o),
      .busy_o           (busy_o)
   );

   function automatic logic [DW-1:0] pay(input int i);
      pay = (DW'(i + 1) << 130) | DW'(32'hA000 + i);
   endfunction

   function automatic logic [NR-1:0] onehot(input int o);
      onehot = NR'(1) << o;
   endfunction

   function automatic logic [RW-1:0] res(input int k);
      res = (RW'(1) << 68) | RW'(32'h5000 + k);
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (unit_valid_o && unit_ready) begin
            if (exp_issue.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_issue: got issue of %0h, required none", unit_data_o);
            end else begin
               mon_e = exp_issue.pop_front();
               chk("issue_data", unit_data_o, mon_e);
            end
         end
         if ((resp_valid_o & resp_ready) != '0) begin
            if (exp_resp.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_resp: got resp_valid %0h, required none", resp_valid_o);
            end else begin
               mon_r = exp_resp.pop_front();
               chk("resp_owner", resp_valid_o, mon_r.oh);
               chk("resp_result", resp_result_o, mon_r.res);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int o);
      exp_issue.push_back(pay(o));
      unit_ready = 1'b1;
      @(negedge clk);
      chk("grant", req_ready_o, onehot(o));
      tick();
      unit_ready = 1'b0;
   endtask

   task automatic complete(input int o, input logic [RW-1:0] r, input int lat, input int hold,
                           input bit flush_resp);
      @(negedge clk);
      chk("busy", busy_o, 1);
      chk("out_ready", unit_out_ready_o, 1);
      for (int i = 1; i < lat; i++) tick();
      if (!flush_resp) exp_resp.push_back('{oh: onehot(o), res: r});
      resp_ready     = (hold > 0 || flush_resp) ? ~onehot(o) : onehot(o);
      unit_out_valid = 1'b1;
      unit_result    = r;
      tick();
      unit_out_valid = 1'b0;
      @(negedge clk);
      chk("resp_latency", resp_valid_o, onehot(o));
      if (flush_resp) begin
         tick();
         flush = 1'b1;
         @(negedge clk);
         chk("flush_resp_unit_flush", unit_flush_o, 1);
         chk("flush_resp_valid", resp_valid_o, 0);
         tick();
         flush = 1'b0;
         @(negedge clk);
         chk("flush_resp_idle", busy_o, 0);
         chk("flush_resp_no_valid", resp_valid_o, 0);
      end else if (hold > 0) begin
         for (int h = 1; h < hold; h++) begin
            tick();
            @(negedge clk);
            chk("hold_valid", resp_valid_o, onehot(o));
            chk("hold_result", resp_result_o, r);
            chk("hold_no_issue", unit_valid_o, 0);
         end
         tick();
         resp_ready = onehot(o);
         @(negedge clk);
      end
      tick();
      resp_ready = '0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; req_valid = '0; unit_ready = 1'b0;
      unit_out_valid = 1'b0; unit_result = '0; resp_ready = '0;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pay(i);

      // Reset with random inputs
      tick();
      for (int c = 0; c < 3; c++) begin
         req_valid      = NR'($urandom());
         unit_ready     = 1'($urandom());
         unit_out_valid = 1'($urandom());
         resp_ready     = NR'($urandom());
         flush          = 1'($urandom());
         unit_result    = RW'({$urandom(), $urandom(), $urandom()});
         @(negedge clk);
         chk("rst_unit_valid", unit_valid_o, 0);
         chk("rst_req_ready", req_ready_o, 0);
         chk("rst_resp_valid", resp_valid_o, 0);
         chk("rst_out_ready", unit_out_ready_o, 0);
         chk("rst_busy", busy_o, 0);
         tick();
      end
      req_valid = '0; unit_ready = 1'b0; unit_out_valid = 1'b0; resp_ready = '0; flush = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_valid", unit_valid_o, 0);
      chk("idle_busy", busy_o, 0);
      tick();

      // Round robin: all valid, latency 10 -> 0,1,2,3,0
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         issue(k % NR);
         complete(k % NR, res(k), 10, 0, 1'b0);
      end

      // Backpressure on owner 2 (rr_ptr=1); non-owner readies asserted
      req_valid = 4'b0100;
      issue(2);
      req_valid = 4'b1011;
      complete(2, RW'(12'hABC), 3, 4, 1'b0);

      // Wrap: rr_ptr=3, req3 then req0
      req_valid = 4'b1000;
      issue(3);
      req_valid = 4'b0001;
      complete(3, res(10), 2, 0, 1'b0);
      issue(0);
      req_valid = '0;
      complete(0, res(11), 2, 0, 1'b0);

      // rr_ptr=1 now: all valid grants 1, then req3 alone -> rr_ptr=0
      req_valid = 4'hF;
      issue(1);
      req_valid = 4'b1000;
      complete(1, res(12), 2, 0, 1'b0);
      issue(3);
      req_valid = '0;
      complete(3, res(13), 2, 0, 1'b0);

      // Lock: rr_ptr=0, req1 offered with unit stalled, req0 rises at cycle 2
      req_valid = 4'b0010;
      unit_ready = 1'b0;
      exp_issue.push_back(pay(1));
      for (int c = 0; c < 5; c++) begin
         if (c == 2) req_valid = 4'b0011;
         @(negedge clk);
         chk("lock_data", unit_data_o, pay(1));
         chk("lock_valid", unit_valid_o, 1);
         chk("lock_no_ready", req_ready_o, 0);
         tick();
      end
      unit_ready = 1'b1;
      @(negedge clk);
      chk("lock_accept", req_ready_o, 4'b0010);
      tick();
      unit_ready = 1'b0;
      req_valid = '0;
      complete(1, res(14), 3, 0, 1'b0);

      // Flush in BUSY (rr_ptr=2)
      req_valid = 4'b0100;
      issue(2);
      req_valid = '0;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_busy_unit_flush", unit_flush_o, 1);
      chk("flush_busy_out_ready", unit_out_ready_o, 0);
      chk("flush_busy_busy", busy_o, 0);
      tick();
      flush = 1'b0;
      unit_out_valid = 1'b1;
      unit_result = res(15);
      @(negedge clk);
      chk("stray_done_ignored", unit_out_ready_o, 0);
      chk("flush_busy_idle", busy_o, 0);
      tick();
      unit_out_valid = 1'b0;
      @(negedge clk);
      chk("stray_no_resp", resp_valid_o, 0);
      tick();

      // Grant follows rr_ptr=3 after flush; then flush in RESP
      req_valid = 4'hF;
      issue(3);
      complete(3, res(16), 4, 0, 1'b1);
      tick();
      issue(0);
      req_valid = '0;
      complete(0, res(17), 2, 0, 1'b0);

      repeat (2) tick();
      chk("issue_queue_drained", exp_issue.size(), 0);
      chk("resp_queue_drained", exp_resp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
